mem_port_arbiter: RTL and testbench

- Shares the single 64-bit unified memory port between the fetch requester (read-only, 32-bit instructions) and the load/store requester (64-bit read/write).
- Sits between the fetch/memory stages and the backing memory. Sequences one transaction at a time over a req/ack handshake.
- Data requests have priority; a starvation counter guarantees forward progress for fetch.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared 64-bit memory port between instruction fetch and load/store.
// Default: data priority with a fetch starvation guard; define ARB_RR_EN for round-robin.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [63:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [63:0]       dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic              owner_data_q, owner_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [63:0]       dm_rdata_q, dm_rdata_d;
  logic              arb, pick_data;

  assign arb = (state_q == StIdle) && (if_req || dm_req);

`ifdef ARB_RR_EN
  logic last_fetch_q, last_fetch_d;

  assign pick_data = dm_req && (!if_req || last_fetch_q);

  always_comb begin
    last_fetch_d = last_fetch_q;
    if (arb) last_fetch_d = !pick_data;
  end

  // Resets to "fetch last" so data takes the first contended grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_fetch_q <= 1'b1;
    else        last_fetch_q <= last_fetch_d;
  end
`else
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
  logic [3:0] starve_q, starve_d;

  assign pick_data = dm_req && (!if_req || (starve_q != StarveMax));

  // Counts data grants that overtook a waiting fetch; any other arbitration clears it.
  always_comb begin
    starve_d = starve_q;
    if (arb) begin
      if (pick_data && if_req) starve_d = starve_q + 4'd1;
      else                     starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`endif

  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (arb) begin
          state_d      = StAccess;
          owner_data_d = pick_data;
          addr_d       = pick_data ? dm_addr : if_addr;
          we_d         = pick_data && dm_we;
          wdata_d      = pick_data ? dm_wdata : '0;
        end
      end
      StAccess: begin
        if (mem_ack) begin
          state_d = StResp;
          if (!owner_data_q) if_rdata_d = addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
          else if (!we_q)    dm_rdata_d = mem_rdata;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_data_q <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  // Grants are decoded from live requests, so gate them while reset is asserted.
  assign if_gnt    = rst_n && arb && !pick_data;
  assign dm_gnt    = rst_n && arb && pick_data;
  assign if_done   = (state_q == StResp) && !owner_data_q;
  assign dm_done   = (state_q == StResp) && owner_data_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_req   = (state_q == StAccess);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: transaction vector table, hand-written corner sequences
// and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned StarveMax = 4;
`ifdef ARB_RR_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_done;
  logic [31:0] dm_addr;
  logic [63:0] dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .STARVE_MAX(StarveMax)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] mrdata;
    int          ack_cyc;   // ACCESS cycle (1-based) in which mem_ack is returned
    logic [63:0] exp_rdata; // fetch: if_rdata; load/store: dm_rdata at done
    bit          exp_we;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_if_hold, exp_dm_hold;
  logic [63:0] memv [logic [31:0]];
  vec_t        vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    logic [31:0] k;
    k = a & ~32'h7;
    if (memv.exists(k)) return memv[k];
    return {k ^ 32'hA5A5_5A5A, ~k};
  endfunction

  // Ends at a drive point: 1 time unit after a rising edge, reset released.
  task automatic do_reset();
    rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    #1;
    chk("rst_mem_req", mem_req, 0);     chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);   chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_done", if_done, 0);     chk("rst_dm_done", dm_done, 0);
    chk("rst_if_gnt", if_gnt, 0);       chk("rst_dm_gnt", dm_gnt, 0);
    chk("rst_if_rdata", if_rdata, 0);   chk("rst_dm_rdata", dm_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_if_hold = '0;
    exp_dm_hold = '0;
  endtask

  // One complete transaction from an idle arbiter, checked cycle by cycle.
  task automatic do_xact(input vec_t v);
    if (v.is_data) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    @(negedge clk);
    chk("vec_if_gnt", if_gnt, !v.is_data);
    chk("vec_dm_gnt", dm_gnt, v.is_data);
    chk("vec_gnt_mem_req", mem_req, 0);
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0;
    for (int k = 1; k <= v.ack_cyc; k++) begin
      mem_ack   = (k == v.ack_cyc);
      mem_rdata = mem_ack ? v.mrdata : ~v.mrdata;
      @(negedge clk);
      chk("vec_mem_req", mem_req, 1);
      chk("vec_mem_addr", mem_addr, v.addr);
      chk("vec_mem_we", mem_we, v.exp_we);
      if (v.is_data && v.we) chk("vec_mem_wdata", mem_wdata, v.wdata);
      chk("vec_early_done", if_done | dm_done, 0);
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    if (!v.is_data) exp_if_hold = {32'h0, v.exp_rdata[31:0]};
    else            exp_dm_hold = v.exp_rdata;
    @(negedge clk);
    chk("vec_if_done", if_done, !v.is_data);
    chk("vec_dm_done", dm_done, v.is_data);
    chk("vec_resp_mem_req", mem_req, 0);
    chk("vec_if_rdata", if_rdata, exp_if_hold);
    chk("vec_dm_rdata", dm_rdata, exp_dm_hold);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit   order_d [10];
    bit   exp_d   [10];
    int   got;
    bit   seen;
    vec_t v;
    // random-model state
    bit          ifp, dmp, dmwe, cur_data, cur_we, last_fetch, any, dwin;
    logic [31:0] ifa, dma, cur_addr;
    logic [63:0] dmwd, cur_wdata, rd;
    int          phase, ack_wait, starve;

    vecs[0] = '{0, 0, 32'h0000_0104, 64'h0, 64'h11223344_AABBCCDD, 2, 64'h11223344, 0};
    vecs[1] = '{1, 1, 32'h0000_0200, 64'hDEADBEEF_CAFEF00D, 64'h0, 2, 64'h0, 1};
    vecs[2] = '{1, 0, 32'h0000_0208, 64'h0, 64'h01234567_89ABCDEF, 1,
                64'h01234567_89ABCDEF, 0};
    vecs[3] = '{0, 0, 32'h0000_0100, 64'h0, 64'h11223344_AABBCCDD, 1, 64'hAABBCCDD, 0};
    vecs[4] = '{1, 1, 32'h0000_0010, 64'h55AA55AA_0F0F0F0F, 64'h0, 3,
                64'h01234567_89ABCDEF, 1};
    vecs[5] = '{0, 0, 32'h0000_7FFC, 64'h0, 64'hCAFE0000_0000BEEF, 1, 64'hCAFE0000, 0};
    vecs[6] = '{1, 0, 32'hFFFF_FFF8, 64'h0, 64'hFEDCBA98_76543210, 4,
                64'hFEDCBA98_76543210, 0};
    vecs[7] = '{0, 0, 32'h0000_0006, 64'h0, 64'h0BAD0000_12345678, 1, 64'h0BAD0000, 0};

    rst_n = 1'b0;
    do_reset();
    foreach (vecs[i]) do_xact(vecs[i]);

    // Both requesters held continuously: grant order.
    if (Rr) exp_d = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    else    exp_d = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    do_reset();
    if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
    mem_ack = 1'b1; mem_rdata = 64'h1;
    got = 0;
    for (int i = 0; i < 10; i++) order_d[i] = 1'b0;
    for (int t = 0; t < 200 && got < 10; t++) begin
      @(negedge clk);
      if (if_gnt && dm_gnt) chk("starve_dual_gnt", 1, 0);
      else if (if_gnt) begin order_d[got] = 1'b0; got++; end
      else if (dm_gnt) begin order_d[got] = 1'b1; got++; end
      @(posedge clk); #1;
    end
    chk("starve_grant_count", got, 10);
    for (int i = 0; i < 10; i++) chk($sformatf("starve_order_%0d", i), order_d[i], exp_d[i]);

    // Contention after a fetch-only period: data first, fetch only after dm_done.
    do_reset();
    do_xact(vecs[0]);
    do_xact(vecs[3]);
    if_req = 1'b1; if_addr = 32'h44; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h88;
    mem_ack = 1'b1; mem_rdata = 64'h2;
    @(negedge clk);
    chk("t4_dm_first", dm_gnt, 1);
    chk("t4_if_not_first", if_gnt, 0);
    @(posedge clk); #1;
    dm_req = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (dm_done) seen = 1'b1;
      chk("t4_fetch_held_off", if_gnt, 0);
      @(posedge clk); #1;
    end
    chk("t4_dm_done_seen", seen, 1);
    @(negedge clk);
    chk("t4_fetch_after_done", if_gnt, 1);
    @(posedge clk); #1;
    if_req = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    mem_ack = 1'b0;

    // Reset asserted mid-ACCESS.
    do_reset();
    if_req = 1'b1; if_addr = 32'h300;
    @(negedge clk);
    chk("t5_gnt", if_gnt, 1);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    chk("t5_in_access", mem_req, 1);
    #2;
    rst_n = 1'b0; if_req = 1'b1; dm_req = 1'b1;
    #1;
    chk("t5_mem_req_drop", mem_req, 0);   chk("t5_mem_addr", mem_addr, 0);
    chk("t5_if_gnt", if_gnt, 0);          chk("t5_dm_gnt", dm_gnt, 0);
    chk("t5_if_done", if_done, 0);        chk("t5_dm_done", dm_done, 0);
    @(posedge clk); #1;
    chk("t5_hold_mem_req", mem_req, 0);   chk("t5_hold_if_gnt", if_gnt, 0);
    if_req = 1'b0; dm_req = 1'b0; rst_n = 1'b1; mem_ack = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("t5_no_done", if_done | dm_done, 0);
      chk("t5_no_mem_req", mem_req, 0);
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    v = '{0, 0, 32'h300, 64'h0, 64'h77778888_99990000, 1, 64'h99990000, 0};
    do_xact(v);

    // mem_ack while idle with no request.
    do_reset();
    mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("t6_mem_req", mem_req, 0);
      chk("t6_done", if_done | dm_done, 0);
      chk("t6_gnt", if_gnt | dm_gnt, 0);
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    chk("t6_if_rdata_kept", if_rdata, 0);
    do_xact(vecs[5]);

    // Randomized traffic against the transaction-level model.
    do_reset();
    ifp = 0; dmp = 0; dmwe = 0; ifa = '0; dma = '0; dmwd = '0;
    cur_data = 0; cur_we = 0; cur_addr = '0; cur_wdata = '0;
    phase = 0; ack_wait = 0; starve = 0; last_fetch = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!ifp && $urandom_range(0, 2) == 0) begin
        ifp = 1; ifa = 32'($urandom_range(0, 15)) << 2;
      end
      if (!dmp && $urandom_range(0, 2) == 0) begin
        dmp = 1; dmwe = 1'($urandom_range(0, 1));
        dma = 32'($urandom_range(0, 7)) << 3; dmwd = {$urandom, $urandom};
      end
      if_req = ifp; if_addr = ifa;
      dm_req = dmp; dm_we = dmwe; dm_addr = dma; dm_wdata = dmwd;
      if (phase == 1) mem_ack = (ack_wait == 0);
      else            mem_ack = ($urandom_range(0, 3) == 0);
      rd = mem_rd(cur_addr);
      mem_rdata = (phase == 1 && mem_ack) ? rd : {$urandom, $urandom};
      @(negedge clk);
      case (phase)
        0: begin
          any  = ifp || dmp;
          dwin = dmp && (!ifp || (Rr ? last_fetch : (starve != StarveMax)));
          chk("rnd_if_gnt", if_gnt, any && !dwin);
          chk("rnd_dm_gnt", dm_gnt, any && dwin);
          chk("rnd_idle_mem_req", mem_req, 0);
          if (any) begin
            cur_data   = dwin;
            last_fetch = !dwin;
            if (dwin) begin
              cur_addr = dma; cur_we = dmwe; cur_wdata = dmwd; dmp = 0;
              starve = ifp ? starve + 1 : 0;
            end else begin
              cur_addr = ifa; cur_we = 0; ifp = 0; starve = 0;
            end
            phase    = 1;
            ack_wait = $urandom_range(0, 3);
          end
        end
        1: begin
          chk("rnd_mem_req", mem_req, 1);
          chk("rnd_mem_addr", mem_addr, cur_addr);
          chk("rnd_mem_we", mem_we, cur_data && cur_we);
          if (cur_data && cur_we) chk("rnd_mem_wdata", mem_wdata, cur_wdata);
          chk("rnd_access_gnt", if_gnt | dm_gnt, 0);
          chk("rnd_access_done", if_done | dm_done, 0);
          if (mem_ack) begin
            if (cur_data && cur_we) memv[cur_addr & ~32'h7] = cur_wdata;
            else if (cur_data)      exp_dm_hold = rd;
            else exp_if_hold = {32'h0, cur_addr[2] ? rd[63:32] : rd[31:0]};
            phase = 2;
          end else begin
            ack_wait--;
          end
        end
        default: begin
          chk("rnd_if_done", if_done, !cur_data);
          chk("rnd_dm_done", dm_done, cur_data);
          chk("rnd_resp_mem_req", mem_req, 0);
          chk("rnd_resp_gnt", if_gnt | dm_gnt, 0);
          chk("rnd_if_rdata", if_rdata, exp_if_hold);
          chk("rnd_dm_rdata", dm_rdata, exp_dm_hold);
          phase = 0;
        end
      endcase
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
